// File: rtl/seven_seg_digit_driver_if.sv
// Signal bundle between the anode scanner/host side and the seven-segment digit driver.
// The master drives the scan pattern and the display data; the slave returns the board outputs.
interface seven_seg_digit_driver_if;
  logic [3:0]  anode_in;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        blink_en;
  logic        load;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_n;
  logic        pending;

  modport master (
    output anode_in, value, dp, blank_lz, blink_en, load,
    input  anode, seg, dp_n, pending
  );

  modport slave (
    input  anode_in, value, dp, blank_lz, blink_en, load,
    output anode, seg, dp_n, pending
  );
endinterface

// File: rtl/seven_seg_digit_driver.sv
// Four-digit seven-segment driver: resynchronises the scanner's anode pattern and hex-decodes the selected nibble.
// It commits new values only at frame boundaries, and adds leading-zero blanking and whole-display blinking.
module seven_seg_digit_driver #(
  parameter int BLINK_FRAMES = 64
) (
  input logic                    clock,
  input logic                    reset,
  seven_seg_digit_driver_if.slave bus
);

  localparam int                CNT_W    = $clog2(BLINK_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic is_digit_sel(input logic [3:0] p);
    return (p == 4'b1110) || (p == 4'b1101) || (p == 4'b1011) || (p == 4'b0111);
  endfunction

  logic [3:0]       s1_r, s2_r, cur_r;
  logic [15:0]      shadow_value_r, disp_value_r;
  logic [3:0]       shadow_dp_r, disp_dp_r;
  logic             shadow_blz_r, disp_blz_r;
  logic             pending_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             blink_phase_r;
  logic [3:0]       anode_r;
  logic [6:0]       seg_r;
  logic             dp_n_r;

  logic             accept_s;
  logic             frame_start_s;
  logic [1:0]       sel_s;
  logic             sel_ok_s;
  logic [3:0]       nib_s;
  logic             blank_s;
  logic             dark_s;
  logic [3:0]       anode_nx_s;
  logic [6:0]       seg_nx_s;
  logic             dp_n_nx_s;

  // A pattern is only trusted once two consecutive samples agree and it is a legal one-hot select.
  assign accept_s      = (s1_r == s2_r) && is_digit_sel(s2_r);
  assign frame_start_s = accept_s && (s2_r == 4'b1110) && (cur_r != 4'b1110);

  // Two-stage resync of the anode pattern and the accepted current digit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r  <= 4'b1111;
      s2_r  <= 4'b1111;
      cur_r <= 4'b1111;
    end else begin
      s1_r <= bus.anode_in;
      s2_r <= s1_r;
      if (accept_s) begin
        cur_r <= s2_r;
      end
    end
  end

  // Shadow capture on load; commit to the display registers only at a frame boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_value_r <= 16'h0000;
      shadow_dp_r    <= 4'b0000;
      shadow_blz_r   <= 1'b0;
      disp_value_r   <= 16'h0000;
      disp_dp_r      <= 4'b0000;
      disp_blz_r     <= 1'b0;
      pending_r      <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_value_r <= bus.value;
        shadow_dp_r    <= bus.dp;
        shadow_blz_r   <= bus.blank_lz;
      end
      if (frame_start_s) begin
        pending_r <= 1'b0;
        if (bus.load) begin
          disp_value_r <= bus.value;
          disp_dp_r    <= bus.dp;
          disp_blz_r   <= bus.blank_lz;
        end else begin
          disp_value_r <= shadow_value_r;
          disp_dp_r    <= shadow_dp_r;
          disp_blz_r   <= shadow_blz_r;
        end
      end else if (bus.load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Frame counter and blink phase; disabling blink parks both at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (!bus.blink_en) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (frame_start_s) begin
      if (frame_cnt_r == CNT_LAST) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end
    end
  end

  // Digit selection, leading-zero blanking and next output values.
  always_comb begin
    sel_s      = 2'd0;
    sel_ok_s   = 1'b0;
    blank_s    = 1'b0;
    anode_nx_s = 4'b1111;
    seg_nx_s   = 7'b1111111;
    dp_n_nx_s  = 1'b1;
    case (cur_r)
      4'b1110: begin sel_s = 2'd0; sel_ok_s = 1'b1; end
      4'b1101: begin sel_s = 2'd1; sel_ok_s = 1'b1; end
      4'b1011: begin sel_s = 2'd2; sel_ok_s = 1'b1; end
      4'b0111: begin sel_s = 2'd3; sel_ok_s = 1'b1; end
      default: begin sel_s = 2'd0; sel_ok_s = 1'b0; end
    endcase
    nib_s = disp_value_r[{sel_s, 2'b00} +: 4];
    case (sel_s)
      2'd3:    blank_s = disp_blz_r && (disp_value_r[15:12] == 4'h0);
      2'd2:    blank_s = disp_blz_r && (disp_value_r[15:8] == 8'h00);
      2'd1:    blank_s = disp_blz_r && (disp_value_r[15:4] == 12'h000);
      default: blank_s = 1'b0;
    endcase
    dark_s = bus.blink_en && blink_phase_r;
    if (sel_ok_s && !blank_s && !dark_s) begin
      anode_nx_s = cur_r;
      seg_nx_s   = hex_to_seg(nib_s);
      dp_n_nx_s  = ~disp_dp_r[sel_s];
    end else begin
      anode_nx_s = 4'b1111;
      seg_nx_s   = 7'b1111111;
      dp_n_nx_s  = 1'b1;
    end
  end

  // Registered board outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode_r <= 4'b1111;
      seg_r   <= 7'b1111111;
      dp_n_r  <= 1'b1;
    end else begin
      anode_r <= anode_nx_s;
      seg_r   <= seg_nx_s;
      dp_n_r  <= dp_n_nx_s;
    end
  end

  assign bus.anode   = anode_r;
  assign bus.seg     = seg_r;
  assign bus.dp_n    = dp_n_r;
  assign bus.pending = pending_r;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Self-checking bench for seven_seg_digit_driver: scan walks, deferred commits, blanking, blinking, glitches, async reset.
// Expected outputs are queued when a digit is driven and popped when the DUT output is due.
module tb_seven_seg_digit_driver;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp_n;
  } exp_t;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SA = 7'b0001000, SC = 7'b1000110, SD = 7'b0100001;
  localparam logic [6:0] SF = 7'b0001110;

  logic clock = 1'b0;
  logic reset = 1'b1;
  exp_t sb_q[$];
  exp_t prev_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  seven_seg_digit_driver_if bus();

  seven_seg_digit_driver #(.BLINK_FRAMES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.anode = a;
    e.seg   = s;
    e.dp_n  = d;
    return e;
  endfunction

  function automatic exp_t off_exp();
    return mk(4'b1111, 7'b1111111, 1'b1);
  endfunction

  // Drive one scan digit; optionally pulse load on the cycle the pattern is accepted.
  task automatic step(input logic [3:0] pat, input exp_t e, input logic ld, input logic [15:0] lv,
                      input logic [3:0] ldp, input logic lblz, input string name);
    exp_t got;
    exp_t want;
    @(negedge clock);
    bus.anode_in = pat;
    sb_q.push_back(e);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    if (ld) begin
      bus.value = lv; bus.dp = ldp; bus.blank_lz = lblz; bus.load = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    bus.load = 1'b0;
    got = {bus.anode, bus.seg, bus.dp_n};
    n_cmp++;
    if (got !== prev_exp) begin
      n_err++;
      $display("FAIL %s_early: got anode=%b seg=%b dp_n=%b, want anode=%b seg=%b dp_n=%b",
               name, got.anode, got.seg, got.dp_n, prev_exp.anode, prev_exp.seg, prev_exp.dp_n);
    end
    @(posedge clock);
    @(negedge clock);
    want = sb_q.pop_front();
    got  = {bus.anode, bus.seg, bus.dp_n};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got anode=%b seg=%b dp_n=%b, want anode=%b seg=%b dp_n=%b",
               name, got.anode, got.seg, got.dp_n, want.anode, want.seg, want.dp_n);
    end
    prev_exp = want;
    repeat (4) @(posedge clock);
  endtask

  task automatic digit(input logic [3:0] pat, input exp_t e, input string name);
    step(pat, e, 1'b0, 16'h0000, 4'b0000, 1'b0, name);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    @(negedge clock);
    bus.value = v; bus.dp = d; bus.blank_lz = b; bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0; bus.value = 16'hDEAD; bus.dp = 4'b1010; bus.blank_lz = ~b;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #3;
    n_cmp++; if (bus.anode !== 4'b1111) begin n_err++; $display("FAIL reset_anode: got %b want 1111", bus.anode); end
    n_cmp++; if (bus.seg !== 7'b1111111) begin n_err++; $display("FAIL reset_seg: got %b want 1111111", bus.seg); end
    n_cmp++; if (bus.dp_n !== 1'b1) begin n_err++; $display("FAIL reset_dp_n: got %b want 1", bus.dp_n); end
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", bus.pending); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    prev_exp = off_exp();
  endtask

  task automatic test_walk();
    do_load(16'h1A2F, 4'b0100, 1'b0);
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL walk_pending_set: got %b want 1", bus.pending); end
    digit(4'b1110, mk(4'b1110, SF, 1'b1), "walk_d0");
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL walk_pending_clr: got %b want 0", bus.pending); end
    digit(4'b1101, mk(4'b1101, S2, 1'b1), "walk_d1");
    digit(4'b1011, mk(4'b1011, SA, 1'b0), "walk_d2");
    digit(4'b0111, mk(4'b0111, S1, 1'b1), "walk_d3");
  endtask

  task automatic test_midframe_load();
    digit(4'b1110, mk(4'b1110, SF, 1'b1), "mid_d0");
    digit(4'b1101, mk(4'b1101, S2, 1'b1), "mid_d1");
    digit(4'b1011, mk(4'b1011, SA, 1'b0), "mid_d2");
    do_load(16'h0000, 4'b0000, 1'b0);
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_set: got %b want 1", bus.pending); end
    digit(4'b0111, mk(4'b0111, S1, 1'b1), "mid_d3_old");
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_hold: got %b want 1", bus.pending); end
    digit(4'b1110, mk(4'b1110, S0, 1'b1), "mid_new_d0");
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL mid_pending_clr: got %b want 0", bus.pending); end
    digit(4'b1101, mk(4'b1101, S0, 1'b1), "mid_new_d1");
    digit(4'b1011, mk(4'b1011, S0, 1'b1), "mid_new_d2");
    digit(4'b0111, mk(4'b0111, S0, 1'b1), "mid_new_d3");
  endtask

  task automatic test_blank();
    do_load(16'h0030, 4'b1111, 1'b1);
    digit(4'b1110, mk(4'b1110, S0, 1'b0), "blz30_d0");
    digit(4'b1101, mk(4'b1101, S3, 1'b0), "blz30_d1");
    digit(4'b1011, off_exp(), "blz30_d2");
    digit(4'b0111, off_exp(), "blz30_d3");
    do_load(16'h0000, 4'b0000, 1'b1);
    digit(4'b1110, mk(4'b1110, S0, 1'b1), "blz0_d0");
    digit(4'b1101, off_exp(), "blz0_d1");
    digit(4'b1011, off_exp(), "blz0_d2");
    digit(4'b0111, off_exp(), "blz0_d3");
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    bus.value = 16'h1234; bus.dp = 4'b1111; bus.blank_lz = 1'b1; bus.load = 1'b1;
    @(negedge clock);
    bus.value = 16'h5678; bus.dp = 4'b0000; bus.blank_lz = 1'b0;
    @(negedge clock);
    bus.load = 1'b0; bus.value = 16'hBEEF;
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL b2b_pending: got %b want 1", bus.pending); end
    digit(4'b1110, mk(4'b1110, S8, 1'b1), "b2b_d0");
    digit(4'b1101, mk(4'b1101, S7, 1'b1), "b2b_d1");
    digit(4'b1011, mk(4'b1011, S6, 1'b1), "b2b_d2");
    digit(4'b0111, mk(4'b0111, S5, 1'b1), "b2b_d3");
  endtask

  task automatic test_load_at_commit();
    step(4'b1110, mk(4'b1110, S9, 1'b1), 1'b1, 16'hC0D9, 4'b0000, 1'b0, "commit_d0");
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL commit_pending: got %b want 0", bus.pending); end
    digit(4'b1101, mk(4'b1101, SD, 1'b1), "commit_d1");
    digit(4'b1011, mk(4'b1011, S0, 1'b1), "commit_d2");
    digit(4'b0111, mk(4'b0111, SC, 1'b1), "commit_d3");
  endtask

  task automatic test_blink();
    logic [3:0] pats [4];
    logic [6:0] segs [4];
    logic       lit  [6];
    pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    segs = '{S9, SD, S0, SC};
    lit  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clock);
    bus.blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < 4; d++) begin
        if (f == 5 && d == 1) break;
        digit(pats[d], lit[f] ? mk(pats[d], segs[d], 1'b1) : off_exp(), $sformatf("blink_f%0d_d%0d", f, d));
      end
    end
    @(negedge clock);
    bus.blink_en = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (bus.anode !== 4'b1110 || bus.seg !== S9) begin
      n_err++;
      $display("FAIL blink_relight: got anode=%b seg=%b want anode=1110 seg=%b", bus.anode, bus.seg, S9);
    end
    prev_exp = mk(4'b1110, S9, 1'b1);
    digit(4'b1101, mk(4'b1101, SD, 1'b1), "blink_off_d1");
    digit(4'b1011, mk(4'b1011, S0, 1'b1), "blink_off_d2");
    digit(4'b0111, mk(4'b0111, SC, 1'b1), "blink_off_d3");
  endtask

  task automatic test_glitch();
    do_load(16'hFFFF, 4'b0001, 1'b0);
    @(negedge clock);
    bus.anode_in = 4'b1010;
    @(negedge clock);
    bus.anode_in = 4'b0111;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      n_cmp++;
      if (bus.anode !== 4'b0111 || bus.pending !== 1'b1) begin
        n_err++;
        $display("FAIL glitch_%0d: got anode=%b pending=%b want anode=0111 pending=1", i, bus.anode, bus.pending);
      end
      if (i < 20) bus.anode_in = (i % 2 == 0) ? 4'b1101 : 4'b0111;
    end
    digit(4'b1110, mk(4'b1110, SF, 1'b0), "glitch_commit_d0");
    n_cmp++; if (bus.pending !== 1'b0) begin n_err++; $display("FAIL glitch_pending_clr: got %b want 0", bus.pending); end
  endtask

  task automatic test_async_reset();
    do_load(16'h4321, 4'b0000, 1'b0);
    n_cmp++; if (bus.pending !== 1'b1) begin n_err++; $display("FAIL areset_pre_pending: got %b want 1", bus.pending); end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.anode !== 4'b1111 || bus.seg !== 7'b1111111 || bus.dp_n !== 1'b1 || bus.pending !== 1'b0) begin
      n_err++;
      $display("FAIL areset_async: got anode=%b seg=%b dp_n=%b pending=%b want 1111 1111111 1 0",
               bus.anode, bus.seg, bus.dp_n, bus.pending);
    end
    bus.anode_in = 4'b1111;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    prev_exp = off_exp();
    digit(4'b1110, mk(4'b1110, S0, 1'b1), "areset_after_d0");
  endtask

  initial begin
    bus.anode_in = 4'b1111;
    bus.value    = 16'h0000;
    bus.dp       = 4'b0000;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    bus.load     = 1'b0;
    test_reset();
    test_walk();
    test_midframe_load();
    test_blank();
    test_back_to_back();
    test_load_at_commit();
    test_blink();
    test_glitch();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
